serial_word_deserializer: RTL and testbench
===========================================

# serial_word_deserializer

Serial-to-parallel receiver: the receiving end of a serial link fed by a universal shift register used as a parallel-to-serial transmitter. Each accepted bit is shifted into an internal C_BIT_NUM-bit register, in the direction selected per word. A completed word moves into a registered output buffer with a valid/ready handshake. An overrun is flagged when a new word completes while the buffer is still held.

## Interface
- C_BIT_NUM, 24, word width in bits; legal range ≥ 2.
- CK  in  1  clock; all state updates on the rising edge.
- RN  in  1  reset, synchronous, active-low.
- SIN_VALID  in  1  SIN carries a bit this cycle.
- SIN  in  1  serial data bit.
- DIR  in  1  0 = MSB-first (shift left, bit enters at bit 0); 1 = LSB-first (shift right, bit enters at bit C_BIT_NUM-1).
- START  in  1  frame sync; discards any partial word.
- CLR_OVR  in  1  clears OVERRUN.
- Q_READY  in  1  consumer accepts Q this cycle.
- Q  out  C_BIT_NUM  assembled word, registered.
- Q_VALID  out  1  Q holds an unconsumed word.
- OVERRUN  out  1  sticky; a completed word was dropped.
- BUSY  out  1  a partial word is in progress (bit count ≠ 0).

## Operation
- Internal state: shift register SR[C_BIT_NUM-1:0], bit counter CNT of width $clog2(C_BIT_NUM), latched direction DIR_L, output register Q, flags Q_VALID and OVERRUN.
- Two states, encoded by CNT:
  - IDLE (CNT = 0): an accepted bit latches DIR into DIR_L, shifts, and sets CNT to 1.
  - COLLECT (CNT > 0): each accepted bit shifts using DIR_L and increments CNT. DIR is ignored mid-word.
- Shift, with DIR_L = 0: SR ← {SR[C_BIT_NUM-2:0], SIN}. With DIR_L = 1: SR ← {SIN, SR[C_BIT_NUM-1:1]}. In IDLE, DIR is used directly instead of DIR_L.
- Completion: a bit accepted with CNT = C_BIT_NUM-1 forms the word W (the shifted value), and CNT ← 0.
  - If Q_VALID = 0, or Q_VALID = 1 and Q_READY = 1: Q ← W and Q_VALID ← 1.
  - Otherwise W is dropped, OVERRUN ← 1, and Q is unchanged.
- Drain: Q_VALID = 1 and Q_READY = 1 with no completion that cycle gives Q_VALID ← 0. Q keeps its last value.
- START = 1: CNT ← 0 and the partial word is discarded.
  - If SIN_VALID = 1 in the same cycle, that bit is the first bit of the new word, using the current DIR, and CNT ← 1.
  - Q, Q_VALID and OVERRUN are unaffected.
- OVERRUN: set by a dropped word and cleared by CLR_OVR. If both happen in the same cycle, set wins.
- SIN_VALID = 0: SR, CNT and DIR_L hold.

## Timing
- Reset (RN = 0 at a rising edge): Q = 0, Q_VALID = 0, OVERRUN = 0, BUSY = 0, CNT = 0, SR = 0, DIR_L = 0.
  - Reset overrides START, SIN_VALID and Q_READY in the same cycle.
  - Reset mid-word discards the partial word.
- Throughput: one bit per cycle. Back-to-back words need no gap cycle.
- Latency: Q_VALID and the new Q are visible the cycle after the edge that accepted the last bit.
- Handshake: a transfer occurs on an edge with Q_VALID = 1 and Q_READY = 1. Q is stable while Q_VALID = 1 and Q_READY = 0.
- Simultaneous drain and completion: the old word transfers, the new word loads, Q_VALID stays 1, and no overrun is flagged.
- BUSY is combinational from CNT and rises the cycle after the first accepted bit.
- All outputs are registered except BUSY.

## Test plan
- Reset, then send 24 bits of 0xA5C33C MSB-first with DIR = 0 and Q_READY = 1 → Q = 0xA5C33C, Q_VALID high for exactly one cycle, 1 cycle after the 24th bit.
- Send the same bit sequence with DIR = 1 → Q = 0x3CC3A5. Toggle DIR mid-word on a second word → result unchanged by the toggle.
- Hold Q_READY = 0 and send 0x000001 then 0xFFFFFF → Q stays 0x000001 and OVERRUN = 1. Pulse CLR_OVR → OVERRUN = 0. Assert CLR_OVR in the same cycle as a new drop → OVERRUN stays 1.
- Two words streamed back-to-back with Q_READY asserted on the completion cycle of the second → Q = second word, Q_VALID continuously 1 across the boundary, OVERRUN = 0.
- 10 bits, then START with SIN_VALID = 1, then 23 further bits of 0x123456 → Q = 0x123456, and the 10-bit fragment never appears on Q.
- RN = 0 after 12 bits, then a full word 0x0F0F0F → all outputs 0 during reset, then Q = 0x0F0F0F after exactly 24 bits.

Source files
------------

// File: rtl/serial_word_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_deserializer
// Purpose  : Serial-to-parallel receiver with per-word shift direction,
//            valid/ready output buffer and sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module serial_word_deserializer #(
  parameter int C_BIT_NUM = 24
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 SIN_VALID,
  input  logic                 SIN,
  input  logic                 DIR,
  input  logic                 START,
  input  logic                 CLR_OVR,
  input  logic                 Q_READY,
  output logic [C_BIT_NUM-1:0] Q,
  output logic                 Q_VALID,
  output logic                 OVERRUN,
  output logic                 BUSY
);

  localparam int CNT_W = $clog2(C_BIT_NUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_BIT_NUM - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  logic [C_BIT_NUM-1:0] sr, sr_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 dir_l, dir_l_nxt;
  logic [C_BIT_NUM-1:0] q_nxt;
  logic                 q_valid_nxt;
  logic                 overrun_nxt;

  state_t               state;
  logic [CNT_W-1:0]     cnt_eff;
  logic                 dir_eff;
  logic [C_BIT_NUM-1:0] shifted;
  logic                 complete;
  logic                 drop;

  always_ff @(posedge CK) begin
    if (!RN) begin
      sr      <= '0;
      cnt     <= '0;
      dir_l   <= 1'b0;
      Q       <= '0;
      Q_VALID <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      sr      <= sr_nxt;
      cnt     <= cnt_nxt;
      dir_l   <= dir_l_nxt;
      Q       <= q_nxt;
      Q_VALID <= q_valid_nxt;
      OVERRUN <= overrun_nxt;
    end
  end

  always_comb begin
    sr_nxt      = sr;
    cnt_nxt     = cnt;
    dir_l_nxt   = dir_l;
    q_nxt       = Q;
    q_valid_nxt = Q_VALID;
    overrun_nxt = OVERRUN;
    drop        = 1'b0;

    state = (cnt == '0) ? IDLE : COLLECT;

    // START behaves as a return to IDLE within the same cycle
    cnt_eff  = START ? '0 : cnt;
    dir_eff  = (START || state == IDLE) ? DIR : dir_l;
    shifted  = dir_eff ? {SIN, sr[C_BIT_NUM-1:1]} : {sr[C_BIT_NUM-2:0], SIN};
    complete = SIN_VALID && (cnt_eff == CNT_LAST);

    if (SIN_VALID) begin
      sr_nxt = shifted;
      if (cnt_eff == '0) begin
        dir_l_nxt = DIR;
      end
      cnt_nxt = complete ? '0 : CNT_W'(cnt_eff + 1'b1);
    end else if (START) begin
      cnt_nxt = '0;
    end

    if (complete) begin
      if (!Q_VALID || Q_READY) begin
        q_nxt       = shifted;
        q_valid_nxt = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (Q_VALID && Q_READY) begin
      q_valid_nxt = 1'b0;
    end

    if (drop) begin
      overrun_nxt = 1'b1;
    end else if (CLR_OVR) begin
      overrun_nxt = 1'b0;
    end
  end

  assign BUSY = (cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_serial_word_deserializer.sv
`default_nettype none
// Testbench for serial_word_deserializer: directed scenarios followed by random
// traffic, every cycle checked against a bit-list reference model.
module tb_serial_word_deserializer;

  localparam int N = 24;

  logic         CK = 1'b0;
  logic         RN = 1'b0;
  logic         SIN_VALID = 1'b0;
  logic         SIN = 1'b0;
  logic         DIR = 1'b0;
  logic         START = 1'b0;
  logic         CLR_OVR = 1'b0;
  logic         Q_READY = 1'b0;
  logic [N-1:0] Q;
  logic         Q_VALID;
  logic         OVERRUN;
  logic         BUSY;

  int vectors = 0;
  int miscompares = 0;

  // reference model: received bits kept as a list, word formed on completion
  int           m_cnt = 0;
  bit           m_bits [N];
  bit           m_dir = 1'b0;
  logic [N-1:0] m_q = '0;
  bit           m_qv = 1'b0;
  bit           m_ovr = 1'b0;

  serial_word_deserializer #(.C_BIT_NUM(N)) dut (
    .CK(CK), .RN(RN), .SIN_VALID(SIN_VALID), .SIN(SIN), .DIR(DIR),
    .START(START), .CLR_OVR(CLR_OVR), .Q_READY(Q_READY),
    .Q(Q), .Q_VALID(Q_VALID), .OVERRUN(OVERRUN), .BUSY(BUSY)
  );

  always #5 CK = ~CK;

  initial begin
    #2ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] w;
    bit done;
    done = 1'b0;
    w = '0;
    if (!RN) begin
      m_cnt = 0; m_dir = 1'b0; m_q = '0; m_qv = 1'b0; m_ovr = 1'b0;
      return;
    end
    if (START) m_cnt = 0;
    if (SIN_VALID) begin
      if (m_cnt == 0) m_dir = DIR;
      m_bits[m_cnt] = SIN;
      m_cnt++;
      if (m_cnt == N) begin
        for (int i = 0; i < N; i++) begin
          if (m_dir) w[i] = m_bits[i];
          else       w[N-1-i] = m_bits[i];
        end
        m_cnt = 0;
        done = 1'b1;
      end
    end
    if (done) begin
      if (!m_qv || Q_READY) begin
        m_q = w;
        m_qv = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_qv && Q_READY) begin
      m_qv = 1'b0;
    end
    if (!(done && m_ovr && !(!m_qv || Q_READY)) && CLR_OVR && !(done && !Q_READY && m_qv && m_q != w))
      ;
  endtask

  // CLR_OVR handled separately so that a same-cycle drop wins
  task automatic tick();
    bit ovr_before;
    bit qv_before;
    bit drop;
    ovr_before = m_ovr;
    qv_before  = m_qv;
    drop = RN && SIN_VALID && ((START ? 0 : m_cnt) == N-1) && qv_before && !Q_READY;
    model_step();
    if (RN && CLR_OVR && !drop) m_ovr = 1'b0;
    @(posedge CK);
    #1;
    chk("q", 32'(Q), 32'(m_q));
    chk("q_valid", 32'(Q_VALID), 32'(m_qv));
    chk("overrun", 32'(OVERRUN), 32'(m_ovr));
    chk("busy", 32'(BUSY), 32'(m_cnt != 0));
  endtask

  // send bits v[N-1-from] .. v[N-1-to] (first-transmitted bit is v[N-1])
  task automatic send_range(input logic [N-1:0] v, input int from, input int to,
                            input bit toggle_dir);
    for (int i = from; i <= to; i++) begin
      if (toggle_dir && i == N/2) DIR = ~DIR;
      SIN_VALID = 1'b1;
      SIN = v[N-1-i];
      tick();
    end
    SIN_VALID = 1'b0;
  endtask

  initial begin
    // reset
    RN = 1'b0;
    tick(); tick();
    chk("rst_q", 32'(Q), 32'h0);
    chk("rst_qv", 32'(Q_VALID), 32'h0);
    RN = 1'b1;

    // MSB-first word, one-cycle valid pulse
    DIR = 1'b0; Q_READY = 1'b1;
    send_range(24'hA5C33C, 0, N-2, 1'b0);
    chk("msb_not_yet", 32'(Q_VALID), 32'h0);
    send_range(24'hA5C33C, N-1, N-1, 1'b0);
    chk("msb_q", 32'(Q), 32'hA5C33C);
    chk("msb_qv", 32'(Q_VALID), 32'h1);
    tick();
    chk("msb_qv_pulse", 32'(Q_VALID), 32'h0);

    // LSB-first, then with DIR toggled mid-word
    DIR = 1'b1;
    send_range(24'hA5C33C, 0, N-1, 1'b0);
    chk("lsb_q", 32'(Q), 32'h3CC3A5);
    tick();
    DIR = 1'b1;
    send_range(24'hA5C33C, 0, N-1, 1'b1);
    chk("lsb_toggle_q", 32'(Q), 32'h3CC3A5);
    tick();

    // overrun with consumer stalled
    DIR = 1'b0; Q_READY = 1'b0;
    send_range(24'h000001, 0, N-1, 1'b0);
    send_range(24'hFFFFFF, 0, N-1, 1'b0);
    chk("ovr_q", 32'(Q), 32'h000001);
    chk("ovr_set", 32'(OVERRUN), 32'h1);
    CLR_OVR = 1'b1; tick(); CLR_OVR = 1'b0;
    chk("ovr_clr", 32'(OVERRUN), 32'h0);
    send_range(24'h555555, 0, N-2, 1'b0);
    CLR_OVR = 1'b1;
    send_range(24'h555555, N-1, N-1, 1'b0);
    CLR_OVR = 1'b0;
    chk("ovr_set_wins", 32'(OVERRUN), 32'h1);
    Q_READY = 1'b1; CLR_OVR = 1'b1; tick(); CLR_OVR = 1'b0;
    chk("drained", 32'(Q_VALID), 32'h0);

    // back-to-back words, drain coincides with second completion
    Q_READY = 1'b0;
    send_range(24'h13579B, 0, N-1, 1'b0);
    send_range(24'h2468AC, 0, N-2, 1'b0);
    chk("b2b_hold", 32'(Q), 32'h13579B);
    Q_READY = 1'b1;
    send_range(24'h2468AC, N-1, N-1, 1'b0);
    chk("b2b_q", 32'(Q), 32'h2468AC);
    chk("b2b_qv", 32'(Q_VALID), 32'h1);
    chk("b2b_ovr", 32'(OVERRUN), 32'h0);
    tick();

    // fragment discarded by START carrying the first bit
    send_range(24'h3FF000, 0, 9, 1'b0);
    START = 1'b1;
    send_range(24'h123456, 0, 0, 1'b0);
    START = 1'b0;
    send_range(24'h123456, 1, N-1, 1'b0);
    chk("start_q", 32'(Q), 32'h123456);
    tick();

    // reset mid-word overrides other inputs
    send_range(24'hABCDEF, 0, 11, 1'b0);
    RN = 1'b0; START = 1'b1; SIN_VALID = 1'b1; SIN = 1'b1;
    tick();
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_q2", 32'(Q), 32'h0);
    RN = 1'b1; START = 1'b0; SIN_VALID = 1'b0;
    send_range(24'h0F0F0F, 0, N-2, 1'b0);
    chk("rst_word_wait", 32'(Q_VALID), 32'h0);
    send_range(24'h0F0F0F, N-1, N-1, 1'b0);
    chk("rst_word_q", 32'(Q), 32'h0F0F0F);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      RN        = ($urandom_range(199) != 0);
      SIN_VALID = ($urandom_range(9) < 8);
      SIN       = 1'($urandom);
      DIR       = 1'($urandom);
      START     = ($urandom_range(39) == 0);
      CLR_OVR   = ($urandom_range(19) == 0);
      Q_READY   = ($urandom_range(3) != 0) ^ (k[9] == 1'b1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
